muldiv_sequencer: RTL

- Multi-cycle multiply/divide unit with its HI/LO register pair, sitting beside the single-cycle ALU in the execute stage.
- Sequences iterative radix-2 MULT/MULTU/DIV/DIVU and owns HI/LO for MFHI/MFLO/MTHI/MTLO.
- Exposes busy for the hazard unit to stall dependent instructions, and accepts a flush abort from the pipeline.

---
 rtl/muldiv_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO pair (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Optional MULDIV_EARLY_OUT_EN: multiplies leave CALC once the remaining multiplier bits are zero.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             abort,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

    state_t               state, state_nx;
    logic [1:0]           op_q;
    logic [CNT_W-1:0]     cnt;
    logic                 fix_ph;
    logic                 sgn_q, sgn_r;
    logic [2*WIDTH-1:0]   acc, mcand;
    logic [WIDTH-1:0]     mplier;

    logic                 is_div, rs_neg, rt_neg, last_step;
    logic [WIDTH-1:0]     rs_mag, rt_mag;
    logic [WIDTH:0]       rem_sh, diff;
    logic [2*WIDTH-1:0]   acc_div;

    assign is_div = op_q[1];
    assign rs_neg = ~op[0] & rs_val[WIDTH-1];
    assign rt_neg = ~op[0] & rt_val[WIDTH-1];
    assign rs_mag = rs_neg ? -rs_val : rs_val;
    assign rt_mag = rt_neg ? -rt_val : rt_val;

    // Restoring step: acc = {remainder, dividend/quotient}, mplier holds the divisor.
    assign rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign diff    = rem_sh - {1'b0, mplier};
    assign acc_div = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                 : {diff[WIDTH-1:0],   acc[WIDTH-2:0], 1'b1};

`ifdef MULDIV_EARLY_OUT_EN
    assign last_step = (cnt == CNT_W'(1)) || (!is_div && (mplier[WIDTH-1:1] == '0));
`else
    assign last_step = (cnt == CNT_W'(1));
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start && !abort) state_nx = PREP;
            PREP: state_nx = (is_div && mplier == '0) ? FIX : CALC;
            CALC: if (last_step) state_nx = FIX;
            FIX:  if (fix_ph) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort && state != IDLE) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            cnt    <= '0;
            fix_ph <= 1'b0;
            sgn_q  <= 1'b0;
            sgn_r  <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start && !abort) begin
                        op_q   <= op;
                        mcand  <= {{WIDTH{1'b0}}, rs_mag};
                        mplier <= rt_mag;
                        sgn_q  <= rs_neg ^ rt_neg;
                        sgn_r  <= rs_neg;
                        fix_ph <= 1'b0;
                    end
                end
                PREP: begin
                    cnt <= CNT_W'(WIDTH);
                    if (!is_div) begin
                        acc <= '0;
                    end else if (mplier == '0) begin
                        // Divide by zero: hand back the dividend as given, no sign fix-up.
                        acc   <= {(sgn_r ? -mcand[WIDTH-1:0] : mcand[WIDTH-1:0]), {WIDTH{1'b1}}};
                        sgn_q <= 1'b0;
                        sgn_r <= 1'b0;
                    end else begin
                        acc <= {{WIDTH{1'b0}}, mcand[WIDTH-1:0]};
                    end
                end
                CALC: begin
                    cnt <= cnt - 1'b1;
                    if (is_div) begin
                        acc <= acc_div;
                    end else begin
                        // Product accumulates in place, so an early exit is still aligned.
                        if (mplier[0]) acc <= acc + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end
                end
                FIX: begin
                    if (!fix_ph) begin
                        fix_ph <= 1'b1;
                        if (is_div)
                            acc <= {(sgn_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH]),
                                    (sgn_q ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0])};
                        else if (sgn_q)
                            acc <= -acc;
                    end else if (!abort) begin
                        hi   <= acc[2*WIDTH-1:WIDTH];
                        lo   <= acc[WIDTH-1:0];
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
